// File: rtl/ov7670_pkg.sv
// Shared types and default geometry for the OV7670 QQVGA capture path.
package ov7670_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 160;
  localparam int unsigned IMG_HEIGHT_DEF = 120;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } cap_state_e;

  // The sensor sends the red/upper-green byte first.
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one camera control bit and flags its rising/falling transitions.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/ov7670_frame_writer.sv
// Converts the OV7670 RGB565 byte stream into one row-major frame RAM write per pixel.
// Optional sticky line-length flag enabled by defining MEM_WRITER_LINE_CHECK_EN.
module ov7670_frame_writer
  import ov7670_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [15:0]           wData,
  output logic                  frame_done
`ifdef MEM_WRITER_LINE_CHECK_EN
  ,
  output logic                  line_err
`endif
);

  // x is wider than the line so oversized lines stay distinguishable from exact ones.
  localparam int unsigned X_W = $clog2(IMG_WIDTH) + 2;
  localparam int unsigned Y_W = $clog2(IMG_HEIGHT + 1);
  localparam logic [X_W-1:0] X_LIM = X_W'(IMG_WIDTH);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(IMG_WIDTH);

  cap_state_e       state;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             byte_phase;
  logic [7:0]       hi_byte;
  logic [7:0]       data_q;

  logic vs_q, vs_rise, vs_fall;
  logic hr_q, hr_rise, hr_fall;

  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  in_bounds;
  logic [X_W-1:0]        x_inc;
  logic [Y_W-1:0]        y_inc;

  sync_edge_det u_vs_det (
    .clk    (pclk),
    .reset  (reset),
    .d      (vsync),
    .q      (vs_q),
    .rise_c (vs_rise),
    .fall_c (vs_fall)
  );

  sync_edge_det u_hr_det (
    .clk    (pclk),
    .reset  (reset),
    .d      (href),
    .q      (hr_q),
    .rise_c (hr_rise),
    .fall_c (hr_fall)
  );

  // Data is delayed to stay aligned with the registered href.
  always_ff @(posedge pclk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data;
    end
  end

  assign row_base  = ROW_PITCH * ADDR_WIDTH'(y);
  assign pix_addr  = row_base + ADDR_WIDTH'(x);
  assign in_bounds = (x < X_LIM) && (y < Y_LIM);
  assign x_inc     = (x == '1)    ? x : x + X_W'(1);
  assign y_inc     = (y >= Y_LIM) ? y : y + Y_W'(1);

  // Capture FSM with registered write port.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= WAIT_VS;
      x          <= '0;
      y          <= '0;
      byte_phase <= 1'b0;
      hi_byte    <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vs_fall) begin
            state      <= CAPTURE;
            x          <= '0;
            y          <= '0;
            byte_phase <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            state      <= WAIT_VS;
            frame_done <= 1'b1;
            x          <= '0;
            y          <= '0;
            byte_phase <= 1'b0;
          end else if (hr_fall) begin
            x          <= '0;
            byte_phase <= 1'b0;
            if (x != '0) begin
              y <= y_inc;
            end
          end else if (hr_q && !vs_q) begin
            // A fresh href always starts on a high byte.
            if (hr_rise || !byte_phase) begin
              hi_byte    <= data_q;
              byte_phase <= 1'b1;
            end else begin
              byte_phase <= 1'b0;
              x          <= x_inc;
              if (in_bounds) begin
                we    <= 1'b1;
                wAddr <= pix_addr;
                wData <= pack_rgb565(hi_byte, data_q);
              end
            end
          end
        end
      endcase
    end
  end

`ifdef MEM_WRITER_LINE_CHECK_EN
  logic line_bad;
  assign line_bad = (x != '0) && (x != X_LIM);

  // Sticky until the next frame starts.
  always_ff @(posedge pclk) begin
    if (reset) begin
      line_err <= 1'b0;
    end else if (vs_fall) begin
      line_err <= 1'b0;
    end else if ((state == CAPTURE) && !vs_rise && hr_fall && line_bad) begin
      line_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Randomized and directed bench for ov7670_frame_writer with a line-level scoreboard.
module tb_ov7670_frame_writer;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int AW = 15;

  logic          pclk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          href;
  logic [7:0]    data;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          frame_done;
`ifdef MEM_WRITER_LINE_CHECK_EN
  logic          line_err;
`endif

  ov7670_frame_writer dut (
    .pclk       (pclk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done)
`ifdef MEM_WRITER_LINE_CHECK_EN
    ,
    .line_err   (line_err)
`endif
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t exp_q[$];
  int  fd_q[$];
  int  le_c_q[$];
  bit  le_v_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  int            n_wr = 0;
  int            n_fd = 0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;
  int            wlog[$];

  // Line-level model state
  bit   m_cap = 0;
  int   m_y = 0;
  logic m_vs = 1'b0;
  bit   exp_le = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic le_push(input int c, input bit v);
    le_c_q.push_back(c);
    le_v_q.push_back(v);
  endtask

  // Per-cycle comparison against the scoreboard queues
  always @(negedge pclk) begin
    if (chk_en) begin
      bit ew;
      bit efd;
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL write_missing: addr %0d not written at cycle %0d", exp_q[0].a, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      ew = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      chk("we", 32'(we), 32'(ew));
      if (ew) begin
        if (we) begin
          chk("wAddr", 32'(wAddr), 32'(exp_q[0].a));
          chk("wData", 32'(wData), 32'(exp_q[0].d));
        end
        void'(exp_q.pop_front());
      end
      efd = (fd_q.size() > 0) && (fd_q[0] == cyc);
      if (efd) void'(fd_q.pop_front());
      chk("frame_done", 32'(frame_done), 32'(efd));
      while (le_c_q.size() > 0 && le_c_q[0] <= cyc) begin
        exp_le = le_v_q[0];
        void'(le_c_q.pop_front());
        void'(le_v_q.pop_front());
      end
`ifdef MEM_WRITER_LINE_CHECK_EN
      chk("line_err", 32'(line_err), 32'(exp_le));
`endif
    end
    if (we === 1'b1) begin
      n_wr++;
      last_addr = wAddr;
      last_data = wData;
      wlog.push_back(int'(wAddr));
    end
    if (frame_done === 1'b1) n_fd++;
  end

  // One input cycle; vsync edges update the frame-level model
  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge pclk);
    vsync = v;
    href  = h;
    data  = d;
    if (v && !m_vs && m_cap) begin
      fd_q.push_back(cyc + 2);
      m_cap = 0;
      m_y   = 0;
    end else if (!v && m_vs) begin
      if (!m_cap) begin
        m_cap = 1;
        m_y   = 0;
      end
      le_push(cyc + 2, 0);
    end
    m_vs = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(m_vs, 1'b0, 8'($urandom));
  endtask

  task automatic vs_rise();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic vs_fall();
    repeat (3) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    vs_rise();
    vs_fall();
  endtask

  // One href line: pixel p is base+p (or random); optional vsync abort at byte abort_at
  task automatic run_line(input int nbytes, input int abort_at, input bit end_rise,
                          input bit rnd, input logic [15:0] base);
    logic [15:0] pv;
    logic [7:0]  b;
    int          p;
    pv = '0;
    for (int j = 0; j < nbytes; j++) begin
      p = j / 2;
      if (j % 2 == 0) pv = rnd ? 16'($urandom) : 16'(int'(base) + p);
      b = (j % 2 == 0) ? pv[15:8] : pv[7:0];
      if (j == abort_at) drive(1'b1, 1'b1, b);
      else               drive(m_vs, 1'b1, b);
      if ((j % 2 == 1) && m_cap && p < W && m_y < H)
        exp_q.push_back('{cyc + 2, AW'(m_y * W + p), pv});
    end
    if (end_rise) drive(1'b1, 1'b0, 8'h00);
    else          drive(m_vs, 1'b0, 8'h00);
    if (m_cap && nbytes / 2 > 0) begin
      if (m_y < H) m_y++;
      if (nbytes / 2 != W) le_push(cyc + 2, 1);
    end
    repeat (2 + $urandom_range(0, 3)) drive(m_vs, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge pclk);
    reset = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    m_cap = 0;
    m_y   = 0;
    m_vs  = 1'b0;
    le_push(cyc + 1, 0);
    repeat (n - 1) @(negedge pclk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n0;
    int fd0;
    int mark;
    int nl;
    int nb;
    int ab;

    reset = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge pclk);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_wAddr", 32'(wAddr), 32'd0);
    chk("reset_wData", 32'(wData), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
`ifdef MEM_WRITER_LINE_CHECK_EN
    chk("reset_line_err", 32'(line_err), 32'd0);
`endif
    @(negedge pclk);
    reset  = 1'b0;
    chk_en = 1;

    // Streaming before any vsync fall must not write
    run_line(20, -1, 0, 1, 16'h0);
    run_line(20, -1, 0, 1, 16'h0);
    idle(3);
    chk("pre_vsync_writes", 32'(n_wr), 32'd0);

    // Single line of 160 pixels
    vs_pulse();
    run_line(320, -1, 0, 0, 16'hA000);
    idle(4);
    chk("line1_writes", 32'(n_wr), 32'd160);
    chk("line1_last_addr", 32'(last_addr), 32'd159);
    chk("line1_last_data", 32'(last_data), 32'hA09F);
    chk("line1_model_y", 32'(m_y), 32'd1);

    // Rest of a full frame
    for (int l = 1; l < H; l++) run_line(320, -1, 0, 0, 16'(32'hA000 + l * W));
    idle(2);
    vs_rise();
    idle(3);
    chk("frame_writes", 32'(n_wr), 32'd19200);
    chk("frame_last_addr", 32'(last_addr), 32'd19199);
    chk("frame_last_data", 32'(last_data), 32'hEAFF);
    chk("frame_done_count", 32'(n_fd), 32'd1);

    // Oversized line: only 160 pixels stored
    vs_fall();
    n0 = n_wr;
    run_line(340, -1, 0, 1, 16'h0);
    idle(3);
    chk("wide_writes", 32'(n_wr - n0), 32'd160);
    chk("wide_last_addr", 32'(last_addr), 32'd159);
`ifdef MEM_WRITER_LINE_CHECK_EN
    chk("wide_line_err_set", 32'(line_err), 32'd1);
`endif
    vs_pulse();
    idle(3);
`ifdef MEM_WRITER_LINE_CHECK_EN
    chk("line_err_cleared", 32'(line_err), 32'd0);
`endif

    // Odd byte count, next line starts at 160
    mark = wlog.size();
    run_line(5, -1, 0, 1, 16'h0);
    run_line(4, -1, 0, 1, 16'h0);
    idle(3);
    chk("odd_writes", 32'(wlog.size() - mark), 32'd4);
    chk("odd_next_line_addr", 32'(wlog[mark + 2]), 32'd160);

    // vsync rise at line 50, pixel 30
    vs_pulse();
    for (int l = 0; l < 50; l++) run_line(60, -1, 0, 1, 16'h0);
    n0  = n_wr;
    fd0 = n_fd;
    run_line(320, 60, 0, 1, 16'h0);
    run_line(40, -1, 0, 1, 16'h0);
    idle(3);
    chk("abort_writes", 32'(n_wr - n0), 32'd30);
    chk("abort_last_addr", 32'(last_addr), 32'd8029);
    chk("abort_frame_done", 32'(n_fd - fd0), 32'd1);
    vs_fall();
    mark = wlog.size();
    run_line(4, -1, 0, 1, 16'h0);
    idle(3);
    chk("restart_addr", 32'(wlog[mark]), 32'd0);

    // href fall coinciding with vsync rise
    run_line(10, -1, 0, 1, 16'h0);
    run_line(10, -1, 1, 1, 16'h0);
    vs_fall();
    mark = wlog.size();
    run_line(4, -1, 0, 1, 16'h0);
    idle(3);
    chk("coincident_restart_addr", 32'(wlog[mark]), 32'd0);

    // Too many lines: y saturates, no wrap to address 0
    vs_pulse();
    n0 = n_wr;
    for (int l = 0; l < H + 2; l++) run_line(2, -1, 0, 1, 16'h0);
    idle(3);
    chk("tall_writes", 32'(n_wr - n0), 32'd120);
    chk("tall_last_addr", 32'(last_addr), 32'd19040);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      vs_pulse();
      nl = $urandom_range(3, 10);
      for (int l = 0; l < nl; l++) begin
        case ($urandom_range(0, 5))
          0:       nb = 320;
          1:       nb = $urandom_range(0, 3);
          default: nb = $urandom_range(0, 340);
        endcase
        ab = ($urandom_range(0, 9) == 0 && nb > 0) ? $urandom_range(0, nb - 1) : -1;
        run_line(nb, ab, ($urandom_range(0, 15) == 0), 1, 16'h0);
      end
    end

    // Reset mid-frame
    vs_pulse();
    run_line(40, -1, 0, 1, 16'h0);
    idle(3);
    do_reset(3);
    n0 = n_wr;
    run_line(20, -1, 0, 1, 16'h0);
    idle(2);
    chk("post_reset_no_write", 32'(n_wr - n0), 32'd0);
    vs_pulse();
    mark = wlog.size();
    run_line(8, -1, 0, 1, 16'h0);
    vs_rise();
    idle(6);
    chk("post_reset_addr", 32'(wlog[mark]), 32'd0);
    chk("write_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_done_queue_drained", 32'(fd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
